// File: rtl/next_state_bist_pkg.sv
// Shared types and constants for the next-state CUT built-in self test:
// FSM state encoding, vector count, golden response table and MISR setup.
package next_state_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int          N_VECTORS = 8;
  localparam logic [2:0]  LAST_IDX  = 3'(N_VECTORS - 1);
  localparam logic [3:0]  FAIL_MAX  = 4'd8;

  // Expected {s_plus, t_plus} per vector; entry i lives at bits [2i+1:2i].
  // idx 7..0 -> 00,00,10,00,10,11,01,00
  localparam logic [15:0] GOLDEN_TABLE = 16'h08B4;

  localparam int              MISR_W    = 4;
  localparam logic [MISR_W-1:0] MISR_TAPS = 4'b1100;

  // Golden response lookup for a 3-bit vector index.
  function automatic logic [1:0] golden_resp(input logic [2:0] idx);
    return GOLDEN_TABLE[{idx, 1'b0} +: 2];
  endfunction

  // One MISR step: shift left with tapped feedback, then fold in the responses.
  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] sig,
                                                 input logic s_in,
                                                 input logic t_in);
    logic [MISR_W-1:0] nxt;
    nxt    = {sig[MISR_W-2:0], ^(sig & MISR_TAPS)};
    nxt[1] = nxt[1] ^ t_in;
    nxt[0] = nxt[0] ^ s_in;
    return nxt;
  endfunction

endpackage

// File: rtl/next_state_bist_misr.sv
// 4-bit multiple-input signature register compacting the CUT responses.
// Only instantiated when NEXT_STATE_BIST_MISR_EN is defined.
module next_state_bist_misr
  import next_state_bist_pkg::*;
(
  input  logic              Clock,
  input  logic              nReset,
  input  logic              clr,
  input  logic              en,
  input  logic              s_in,
  input  logic              t_in,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] sig_r;

  // Signature register: cleared at run start/abort, stepped once per SAMPLE.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sig_r <= '0;
    end else if (clr) begin
      sig_r <= '0;
    end else if (en) begin
      sig_r <= misr_step(sig_r, s_in, t_in);
    end else begin
      sig_r <= sig_r;
    end
  end

  assign sig = sig_r;

endmodule

// File: rtl/next_state_bist.sv
// BIST controller for a two-flop next-state circuit. Walks the 8 input
// vectors (APPLY then SAMPLE per vector), compares the CUT responses with
// the golden table, counts mismatches and records the first failing vector.
// Optional MISR signature: define NEXT_STATE_BIST_MISR_EN.
module next_state_bist
  import next_state_bist_pkg::*;
(
  input  logic       Clock,
  input  logic       nReset,
  input  logic       start,
  input  logic       abort,
  output logic       vec_s,
  output logic       vec_s_bar,
  output logic       vec_t,
  output logic       vec_t_bar,
  output logic       vec_a,
  input  logic       cut_s_plus,
  input  logic       cut_t_plus,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_count,
  output logic [2:0] first_fail_vec,
  output logic [3:0] signature
);

  state_t     state_r, state_s;
  logic [2:0] idx_r, idx_s;
  logic [3:0] fail_r, fail_s;
  logic [2:0] ffv_r, ffv_s;
  logic       busy_r, done_r, pass_r;
  logic       busy_s, done_s, pass_s;
  logic [1:0] expect_s;
  logic [1:0] resp_s;
  logic       mismatch_s;

  assign expect_s   = golden_resp(idx_r);
  assign resp_s     = {cut_s_plus, cut_t_plus};
  assign mismatch_s = (resp_s != expect_s);

  // Next-state, vector index and result bookkeeping; abort overrides everything.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    fail_s  = fail_r;
    ffv_s   = ffv_r;
    if (abort) begin
      state_s = ST_IDLE;
      idx_s   = 3'd0;
      fail_s  = 4'd0;
      ffv_s   = 3'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_s = ST_APPLY;
            idx_s   = 3'd0;
            fail_s  = 4'd0;
            ffv_s   = 3'd0;
          end else begin
            state_s = state_r;
          end
        end
        ST_APPLY: begin
          // One settle cycle with the vector held.
          state_s = ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (mismatch_s) begin
            if (fail_r == 4'd0) begin
              ffv_s = idx_r;
            end else begin
              ffv_s = ffv_r;
            end
            if (fail_r < FAIL_MAX) begin
              fail_s = fail_r + 4'd1;
            end else begin
              fail_s = fail_r;
            end
          end else begin
            fail_s = fail_r;
          end
          if (idx_r == LAST_IDX) begin
            state_s = ST_DONE;
            idx_s   = idx_r;
          end else begin
            state_s = ST_APPLY;
            idx_s   = idx_r + 3'd1;
          end
        end
        default: begin
          state_s = ST_IDLE;
          idx_s   = 3'd0;
          fail_s  = 4'd0;
          ffv_s   = 3'd0;
        end
      endcase
    end
  end

  assign busy_s = (state_s == ST_APPLY) || (state_s == ST_SAMPLE);
  assign done_s = (state_s == ST_DONE);
  assign pass_s = done_s && (fail_s == 4'd0);

  // State, index, result and status registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_r <= ST_IDLE;
      idx_r   <= 3'd0;
      fail_r  <= 4'd0;
      ffv_r   <= 3'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      fail_r  <= fail_s;
      ffv_r   <= ffv_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
    end
  end

  // Stimulus comes straight from the index register; complements are structural.
  assign vec_s     = idx_r[2];
  assign vec_s_bar = ~idx_r[2];
  assign vec_t     = idx_r[1];
  assign vec_t_bar = ~idx_r[1];
  assign vec_a     = idx_r[0];

  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign fail_count     = fail_r;
  assign first_fail_vec = ffv_r;

`ifdef NEXT_STATE_BIST_MISR_EN
  logic misr_clr_s;
  logic misr_en_s;

  // Clear on abort or on a run starting; step on every SAMPLE cycle.
  assign misr_clr_s = abort | (((state_r == ST_IDLE) || (state_r == ST_DONE)) & start);
  assign misr_en_s  = (state_r == ST_SAMPLE) & ~abort;

  next_state_bist_misr u_misr (
    .Clock  (Clock),
    .nReset (nReset),
    .clr    (misr_clr_s),
    .en     (misr_en_s),
    .s_in   (cut_s_plus),
    .t_in   (cut_t_plus),
    .sig    (signature)
  );
`else
  assign signature = 4'h0;
`endif

endmodule

// File: tb/tb_next_state_bist.sv
// Self-checking bench for next_state_bist: behavioural CUT with injectable
// faults, a run-level reference model and per-cycle output comparison.
module tb_next_state_bist;

  logic       Clock = 1'b0;
  logic       nReset;
  logic       start;
  logic       abort;
  logic       vec_s, vec_s_bar, vec_t, vec_t_bar, vec_a;
  logic       cut_s_plus, cut_t_plus;
  logic       busy, done, pass;
  logic [3:0] fail_count;
  logic [2:0] first_fail_vec;
  logic [3:0] signature;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          fault_mode = 0;        // 0 good, 1 f stuck-at-1, 2 f stuck-at-0
  logic [15:0] flip_vec = 16'h0000;   // extra per-vector response flips
  bit          chk_en = 1'b0;

  // reference model: mode 0 idle, 1 running (step k of 16), 2 done
  int         m_mode, m_k, m_fail, m_ffv;
  logic [3:0] m_sig;

  next_state_bist dut (
    .Clock(Clock), .nReset(nReset), .start(start), .abort(abort),
    .vec_s(vec_s), .vec_s_bar(vec_s_bar), .vec_t(vec_t), .vec_t_bar(vec_t_bar),
    .vec_a(vec_a), .cut_s_plus(cut_s_plus), .cut_t_plus(cut_t_plus),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .first_fail_vec(first_fail_vec), .signature(signature)
  );

  always #5 Clock = ~Clock;

  function automatic logic [1:0] golden(input logic [2:0] i);
    logic s, t, a, sp, tp;
    s  = i[2]; t = i[1]; a = i[0];
    sp = (~s & t) | (s & a & ~t);
    tp = (a & ~s & ~t) | (~a & ~s & t);
    return {sp, tp};
  endfunction

  function automatic logic [1:0] cut_resp(input logic [2:0] i, input int mode,
                                          input logic [15:0] flips);
    logic [1:0] r;
    logic       s, t;
    s = i[2]; t = i[1];
    r = golden(i);
    if (mode == 1) r[1] = ~s & t;
    else if (mode == 2) r[1] = 1'b1;
    return r ^ flips[{i, 1'b0} +: 2];
  endfunction

  logic [1:0] cut_pair;
  assign cut_pair   = cut_resp({vec_s, vec_t, vec_a}, fault_mode, flip_vec);
  assign cut_s_plus = cut_pair[1];
  assign cut_t_plus = cut_pair[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_fail = 0; m_ffv = 0; m_sig = 4'h0;
  endtask

  // Advance the model by one clock edge given the inputs held at that edge.
  task automatic model_step(input logic st, input logic ab);
    logic [1:0] e, g;
    logic [2:0] i;
    if (ab) begin
      model_reset();
    end else if (m_mode != 1) begin
      if (st) begin
        model_reset();
        m_mode = 1;
      end
    end else begin
      if (m_k % 2 == 1) begin
        i = 3'(m_k / 2);
        e = golden(i);
        g = cut_resp(i, fault_mode, flip_vec);
        if (e != g) begin
          if (m_fail == 0) m_ffv = int'(i);
          if (m_fail < 8) m_fail++;
        end
        m_sig = {m_sig[2:0], m_sig[3] ^ m_sig[2]} ^ {2'b00, g[0], g[1]};
      end
      if (m_k == 15) m_mode = 2;
      else m_k++;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge Clock) begin
    if (chk_en) begin
      logic [2:0] ei;
      logic       ebs, ebt, epass;
      logic [3:0] esig;
      ei    = (m_mode == 1) ? 3'(m_k / 2) : ((m_mode == 2) ? 3'd7 : 3'd0);
      ebs   = ~ei[2];
      ebt   = ~ei[1];
      epass = (m_mode == 2) && (m_fail == 0);
`ifdef NEXT_STATE_BIST_MISR_EN
      esig  = m_sig;
`else
      esig  = 4'h0;
`endif
      check("vec_s", vec_s, ei[2]);
      check("vec_s_bar", vec_s_bar, ebs);
      check("vec_t", vec_t, ei[1]);
      check("vec_t_bar", vec_t_bar, ebt);
      check("vec_a", vec_a, ei[0]);
      check("busy", busy, m_mode == 1);
      check("done", done, m_mode == 2);
      check("pass", pass, epass);
      check("fail_count", fail_count, m_fail);
      check("first_fail_vec", first_fail_vec, m_ffv);
      check("signature", signature, esig);
    end
  end

  task automatic cycle(input logic st, input logic ab);
    start = st;
    abort = ab;
    @(posedge Clock);
    model_step(st, ab);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_pass"}, pass, 1'b0);
    check({tag, "_fail"}, fail_count, 4'd0);
    check({tag, "_ffv"}, first_fail_vec, 3'd0);
    check({tag, "_sig"}, signature, 4'h0);
    check({tag, "_vec"}, {vec_s, vec_t, vec_a}, 3'd0);
    check({tag, "_bars"}, {vec_s_bar, vec_t_bar}, 2'b11);
  endtask

  // Start a run and count edges until done; hold_start keeps start high.
  task automatic run_measure(input string tag, input logic hold_start);
    int n;
    cycle(1'b1, 1'b0);
    n = 1;
    while (!done && n < 40) begin
      cycle(hold_start, 1'b0);
      n++;
    end
    check({tag, "_latency"}, n, 17);
  endtask

  logic [3:0] good_sig;

  initial begin
`ifdef NEXT_STATE_BIST_MISR_EN
    good_sig = 4'h6;
`else
    good_sig = 4'h0;
`endif
    nReset = 1'b1; start = 1'b0; abort = 1'b0;
    model_reset();
    #2 nReset = 1'b0;
    #1 check_reset_vals("por");
    chk_en = 1'b1;
    #19 nReset = 1'b1;
    repeat (3) cycle(1'b0, 1'b0);

    // fault-free run
    fault_mode = 0;
    run_measure("good", 1'b0);
    check("good_pass", pass, 1'b1);
    check("good_fail", fail_count, 4'd0);
    check("good_ffv", first_fail_vec, 3'd0);
    check("good_sig", signature, good_sig);
    repeat (2) cycle(1'b0, 1'b0);

    // f stuck-at-1, restarted straight from DONE
    fault_mode = 1;
    run_measure("sa1", 1'b0);
    check("sa1_pass", pass, 1'b0);
    check("sa1_fail", fail_count, 4'd1);
    check("sa1_ffv", first_fail_vec, 3'd5);

    // f stuck-at-0
    fault_mode = 2;
    run_measure("sa0", 1'b0);
    check("sa0_fail", fail_count, 4'd5);
    check("sa0_ffv", first_fail_vec, 3'd0);

    // abort during SAMPLE of vector 3, with start in the same cycle
    cycle(1'b1, 1'b0);
    repeat (7) cycle(1'b0, 1'b0);
    check("pre_abort_busy", busy, 1'b1);
    check("pre_abort_fail", fail_count, 4'd2);
    check("pre_abort_vec", {vec_s, vec_t, vec_a}, 3'd3);
    cycle(1'b1, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_fail", fail_count, 4'd0);
    check("abort_ffv", first_fail_vec, 3'd0);
    cycle(1'b0, 1'b0);
    run_measure("rerun", 1'b0);
    check("rerun_fail", fail_count, 4'd5);

    // asynchronous reset in the middle of a run (vector 4 applied)
    fault_mode = 0;
    cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);
    check("mid_vec", {vec_s, vec_t, vec_a}, 3'd4);
    nReset = 1'b0;
    #1 check_reset_vals("mid_rst");
    model_reset();
    start = 1'b0; abort = 1'b0;
    repeat (2) @(posedge Clock);
    #3 nReset = 1'b1;
    repeat (3) cycle(1'b0, 1'b0);
    check("post_rst_idle", busy, 1'b0);

    // start held high for the whole run must not restart it
    run_measure("hold", 1'b1);
    check("hold_pass", pass, 1'b1);
    cycle(1'b0, 1'b0);

    // randomized traffic against the model
    for (int r = 0; r < 600; r++) begin
      if (m_mode != 1 && $urandom_range(0, 3) == 0) begin
        fault_mode = int'($urandom_range(0, 2));
        flip_vec   = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0000;
      end
      cycle($urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/next_state_bist.md
NEXT_STATE_BIST -- requirements
Module: next_state_bist

Interface
REQ-001 Clock  input  1  rising-edge system clock.
REQ-002 nReset  input  1  asynchronous active-low reset.
REQ-003 start  input  1  request test run; sampled only in IDLE or DONE.
REQ-004 abort  input  1  terminate run; return to IDLE next edge.
REQ-005 vec_s, vec_s_bar, vec_t, vec_t_bar, vec_a  output  1 each  stimulus to next-state CUT; vec_s_bar = ~vec_s, vec_t_bar = ~vec_t at all times.
REQ-006 cut_s_plus, cut_t_plus  input  1 each  CUT responses.
REQ-007 busy  output  1  high in APPLY/SAMPLE.
REQ-008 done  output  1  high in DONE.
REQ-009 pass  output  1  valid when done; 1 iff fail_count == 0.
REQ-010 fail_count  output  4  number of mismatching vectors, 0..8.
REQ-011 first_fail_vec  output  3  index of first mismatching vector; 0 if none.
REQ-012 signature  output  4  MISR signature (see Configuration).

Function
REQ-013 FSM states IDLE, APPLY, SAMPLE, DONE.
- IDLE --start--> APPLY, idx=0, counters/signature cleared.
- APPLY --> SAMPLE (one settle cycle, vector held).
- SAMPLE --idx<7--> APPLY with idx+1; SAMPLE --idx==7--> DONE.
- DONE --start--> APPLY (fresh run, results cleared); otherwise holds.
REQ-014 Vector index idx is 3 bits: vec_s=idx[2], vec_t=idx[1], vec_a=idx[0]; order 0..7, no wrap beyond 7.
REQ-015 Golden model: s_plus = (~s & t) | (s & a & ~t); t_plus = (a & ~s & ~t) | (~a & ~s & t); expected (s+,t+) for idx 0..7 = 00,01,11,10,00,10,00,00.
REQ-016 In SAMPLE, a mismatch on either output increments fail_count (saturating at 8); first mismatch of a run loads first_fail_vec.
REQ-017 Run latency: start seen in cycle N -> done high in cycle N+17 (16 APPLY/SAMPLE cycles + DONE entry).
REQ-018 start while busy is ignored; start and abort in the same cycle: abort wins.
REQ-019 abort in any state -> IDLE next edge, with fail_count, first_fail_vec and signature cleared.
REQ-020 In IDLE, all vec_* are driven from idx=0 (vec_s_bar=1, vec_t_bar=1).

Reset
REQ-021 nReset low asynchronously forces IDLE, idx=0, busy=0, done=0, pass=0, fail_count=0, first_fail_vec=0, signature=0.
REQ-022 Deassertion takes effect at the next Clock rising edge; no run starts without a subsequent start.

Configuration
REQ-023 Macro NEXT_STATE_BIST_MISR_EN: defined -> 4-bit MISR updated once per SAMPLE.
- next[3:1] = sig[2:0]; next[0] = sig[3]^sig[2].
- Then bit1 ^= cut_t_plus, bit0 ^= cut_s_plus.
- Fault-free final signature = 4'h6.
REQ-024 Undefined -> no MISR logic; signature tied to 4'h0.

Structure
REQ-025 Package next_state_bist_pkg: state enum, N_VECTORS=8, 8-entry golden response table, MISR width and tap constants.
REQ-026 One sub-module, next_state_bist_misr, instantiated only under NEXT_STATE_BIST_MISR_EN; FSM, counters and compare live in the top.

Verification
REQ-027 Fault-free CUT, start pulse -> done after 17 cycles, pass=1, fail_count=0, first_fail_vec=0, signature=4'h6 (with MISR_EN).
REQ-028 CUT with internal node f stuck-at-1 (s_plus = ~s & t) -> pass=0, fail_count=1, first_fail_vec=5.
REQ-029 CUT with f stuck-at-0 (s_plus constant 1) -> fail_count=5, first_fail_vec=0.
REQ-030 abort during idx=3 SAMPLE -> IDLE next cycle, busy=0, fail_count=0; start re-runs all 8 vectors.
REQ-031 nReset pulsed low mid-run (idx=4) -> all outputs at reset values immediately; start repeated while busy -> no restart, latency unchanged.
